// File: rtl/note_sequencer.sv
// Game controller for four note columns: pseudo-random spawn pulses, shared
// light speed, and score/lives/state bookkeeping from per-column event edges.
module note_sequencer #(
  parameter int BASE_GAP    = 64,
  parameter int GAP_STEP    = 4,
  parameter int MIN_GAP     = 16,
  parameter int LEVEL_PTS   = 8,
  parameter int START_LIVES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] hit,
  input  logic [3:0] lost,
  input  logic [3:0] empty,
  output logic [3:0] spawn,
  output logic [3:0] light_speed,
  output logic [9:0] score,
  output logic [2:0] lives,
  output logic       playing,
  output logic       game_over
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2
  } state_t;

  localparam logic [7:0] BASE8  = 8'(BASE_GAP);
  localparam logic [7:0] STEP8  = 8'(GAP_STEP);
  localparam logic [7:0] MIN8   = 8'(MIN_GAP);
  localparam logic [7:0] LEVEL8 = 8'(LEVEL_PTS);

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_lfsr;
  logic [7:0]  r_gap_cnt;
  logic [7:0]  r_acc;
  logic [9:0]  r_score;
  logic [2:0]  r_lives;
  logic [3:0]  r_speed;
  logic [3:0]  r_spawn;
  logic [3:0]  r_prev_hit, r_prev_lost, r_prev_empty;

  logic [3:0]  w_hit_e, w_lost_e, w_empty_e;
  logic [2:0]  w_n_hit, w_n_lost, w_n_empty;
  logic signed [11:0] w_delta, w_score_sum;
  logic [9:0]  w_score_nxt;
  logic [2:0]  w_lives_nxt;
  logic [7:0]  w_acc_sum, w_acc_nxt;
  logic [3:0]  w_speed_nxt;
  logic [7:0]  w_dec, w_gap;
  logic        w_due;
  logic        w_lfsr_fb;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  assign w_hit_e   = hit & ~r_prev_hit;
  assign w_lost_e  = lost & ~r_prev_lost;
  assign w_empty_e = empty & ~r_prev_empty;
  assign w_n_hit   = popcount4(w_hit_e);
  assign w_n_lost  = popcount4(w_lost_e);
  assign w_n_empty = popcount4(w_empty_e);

  // All event edges of a cycle are netted into one signed delta.
  assign w_delta     = $signed({9'd0, w_n_hit}) - $signed({8'd0, w_n_lost, 1'b0})
                     - $signed({9'd0, w_n_empty});
  assign w_score_sum = $signed({2'b00, r_score}) + w_delta;

  always_comb begin
    w_score_nxt = w_score_sum[9:0];
    if (w_score_sum < 12'sd0)
      w_score_nxt = 10'd0;
    else if (w_score_sum > 12'sd1023)
      w_score_nxt = 10'd1023;
  end

  assign w_lives_nxt = (r_lives > w_n_lost) ? (r_lives - w_n_lost) : 3'd0;

  always_comb begin
    w_acc_sum   = r_acc + {5'd0, w_n_hit};
    w_acc_nxt   = w_acc_sum;
    w_speed_nxt = r_speed;
    if (w_acc_sum >= LEVEL8) begin
      w_acc_nxt   = w_acc_sum - LEVEL8;
      w_speed_nxt = (r_speed == 4'd15) ? r_speed : r_speed + 4'd1;
    end
  end

  // Spacing shrinks with speed but never below the floor; compare before
  // subtracting so the 8-bit difference cannot wrap.
  assign w_dec = {4'd0, r_speed} * STEP8;
  always_comb begin
    w_gap = MIN8;
    if (BASE8 > w_dec && (BASE8 - w_dec) > MIN8)
      w_gap = BASE8 - w_dec;
  end

  assign w_due     = (r_state == S_PLAY) && (r_gap_cnt == 8'd0) && (w_lives_nxt != 3'd0);
  assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_OVER: if (start) w_state_nxt = S_PLAY;
      S_PLAY:         if (w_lives_nxt == 3'd0) w_state_nxt = S_OVER;
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr       <= 8'hA5;
      r_gap_cnt    <= 8'd0;
      r_acc        <= 8'd0;
      r_score      <= 10'd0;
      r_lives      <= 3'd0;
      r_speed      <= 4'd0;
      r_spawn      <= 4'd0;
      r_prev_hit   <= 4'd0;
      r_prev_lost  <= 4'd0;
      r_prev_empty <= 4'd0;
    end else begin
      r_lfsr       <= {r_lfsr[6:0], w_lfsr_fb};
      r_prev_hit   <= hit;
      r_prev_lost  <= lost;
      r_prev_empty <= empty;
      r_spawn      <= 4'd0;
      if (r_state != S_PLAY && start) begin
        r_score   <= 10'd0;
        r_lives   <= 3'(START_LIVES);
        r_speed   <= 4'd0;
        r_acc     <= 8'd0;
        r_gap_cnt <= 8'(BASE_GAP - 1);
      end else if (r_state == S_PLAY) begin
        r_score <= w_score_nxt;
        r_lives <= w_lives_nxt;
        r_acc   <= w_acc_nxt;
        r_speed <= w_speed_nxt;
        // Reload uses the speed in effect before this cycle's level step.
        if (r_gap_cnt == 8'd0) begin
          r_gap_cnt <= w_gap - 8'd1;
          r_spawn   <= w_due ? (4'b0001 << r_lfsr[1:0]) : 4'd0;
        end else begin
          r_gap_cnt <= r_gap_cnt - 8'd1;
        end
      end
    end
  end

  assign spawn       = r_spawn;
  assign light_speed = r_speed;
  assign score       = r_score;
  assign lives       = r_lives;
  assign playing     = (r_state == S_PLAY);
  assign game_over   = (r_state == S_OVER);

endmodule

// File: tb/tb_note_sequencer.sv
// Directed and randomized bench for note_sequencer, checked every cycle
// against a rule-level model of the game (absolute spawn schedule, integer scoring).
module tb_note_sequencer;

  localparam int BASE_GAP    = 64;
  localparam int GAP_STEP    = 4;
  localparam int MIN_GAP     = 16;
  localparam int LEVEL_PTS   = 8;
  localparam int START_LIVES = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] hit = 4'd0, lost = 4'd0, empty = 4'd0;
  logic [3:0] spawn, light_speed;
  logic [9:0] score;
  logic [2:0] lives;
  logic       playing, game_over;

  int n_checks = 0;
  int n_errors = 0;

  note_sequencer #(
    .BASE_GAP(BASE_GAP), .GAP_STEP(GAP_STEP), .MIN_GAP(MIN_GAP),
    .LEVEL_PTS(LEVEL_PTS), .START_LIVES(START_LIVES)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .hit(hit), .lost(lost), .empty(empty),
    .spawn(spawn), .light_speed(light_speed), .score(score),
    .lives(lives), .playing(playing), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // Reference model: 0 idle, 1 playing, 2 over.
  int         m_mode = 0;
  int         m_score = 0, m_lives = 0, m_speed = 0, m_acc = 0;
  int         m_cycle = 0, m_next_spawn = 0;
  logic [3:0] m_spawn = 4'd0;
  logic [7:0] m_lfsr = 8'hA5;
  logic [3:0] m_ph = 4'd0, m_pl = 4'd0, m_pe = 4'd0;

  function automatic int gap_of(input int lvl);
    int g;
    g = BASE_GAP - lvl * GAP_STEP;
    return (g < MIN_GAP) ? MIN_GAP : g;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, m_cycle);
    end
  endtask

  task automatic model_edge();
    logic [3:0] eh, el, ee;
    logic [7:0] lfsr_cur;
    int old_speed;
    m_cycle++;
    eh = hit & ~m_ph;  el = lost & ~m_pl;  ee = empty & ~m_pe;
    lfsr_cur = m_lfsr;
    m_spawn = 4'd0;
    if (reset) begin
      m_mode = 0; m_score = 0; m_lives = 0; m_speed = 0; m_acc = 0;
      m_lfsr = 8'hA5; m_ph = 4'd0; m_pl = 4'd0; m_pe = 4'd0;
    end else begin
      m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
      m_ph = hit; m_pl = lost; m_pe = empty;
      if (start && m_mode != 1) begin
        m_mode = 1; m_score = 0; m_lives = START_LIVES; m_speed = 0; m_acc = 0;
        m_next_spawn = m_cycle + BASE_GAP;
      end else if (m_mode == 1) begin
        old_speed = m_speed;
        m_score = m_score + $countones(eh) - 2 * $countones(el) - $countones(ee);
        if (m_score < 0) m_score = 0;
        if (m_score > 1023) m_score = 1023;
        m_lives = m_lives - $countones(el);
        if (m_lives < 0) m_lives = 0;
        m_acc = m_acc + $countones(eh);
        if (m_acc >= LEVEL_PTS) begin
          m_acc = m_acc - LEVEL_PTS;
          if (m_speed < 15) m_speed++;
        end
        if (m_cycle == m_next_spawn) begin
          m_next_spawn = m_cycle + gap_of(old_speed);
          if (m_lives > 0) m_spawn = 4'b0001 << lfsr_cur[1:0];
        end
        if (m_lives == 0) m_mode = 2;
      end
    end
  endtask

  task automatic step(input logic [3:0] h, input logic [3:0] l, input logic [3:0] e,
                      input logic st, input logic rs);
    @(negedge clk);
    hit = h; lost = l; empty = e; start = st; reset = rs;
    @(posedge clk);
    model_edge();
    #1;
    check("spawn", spawn, m_spawn);
    check("light_speed", light_speed, m_speed);
    check("score", score, m_score);
    check("lives", lives, m_lives);
    check("playing", playing, m_mode == 1);
    check("game_over", game_over, m_mode == 2);
    if (spawn != 4'd0) check("spawn_onehot", $countones(spawn), 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic pulse(input logic [3:0] h, input logic [3:0] l, input logic [3:0] e);
    step(h, l, e, 1'b0, 1'b0);
    step(4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
  endtask

  // Idle until the next input applied lands on a due spawn edge.
  task automatic idle_until_due();
    int n;
    n = 0;
    while (m_next_spawn != m_cycle + 1 && n < 300) begin
      idle(1);
      n++;
    end
    check("due_wait_timeout", n < 300, 1);
  endtask

  task automatic wait_spawn(output int at);
    int n;
    n = 0;
    at = -1;
    while (n < 300 && at < 0) begin
      idle(1);
      if (spawn != 4'd0) at = m_cycle;
      n++;
    end
    check("spawn_wait_timeout", at >= 0, 1);
  endtask

  initial begin
    int t_a, t_b;
    logic [3:0] rl;

    repeat (3) step(4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    check("reset_score", score, 0);
    check("reset_lives", lives, 0);
    check("reset_playing", playing, 0);

    step(4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
    check("start_playing", playing, 1);
    idle(140);

    for (int i = 0; i < 8; i++) pulse(4'b0001, 4'd0, 4'd0);
    check("eight_hits_score", score, 8);
    check("eight_hits_speed", light_speed, 1);
    for (int i = 0; i < 20; i++) step(4'b0100, 4'd0, 4'd0, 1'b0, 1'b0);
    idle(1);
    check("held_hit_score", score, 9);

    for (int i = 0; i < 8; i++) pulse(4'd0, 4'd0, 4'b0001);
    check("empties_score", score, 1);
    pulse(4'd0, 4'b0010, 4'd0);
    check("lost_clamp_score", score, 0);
    check("lost_lives", lives, 2);
    pulse(4'd0, 4'd0, 4'b1000);
    check("empty_at_zero", score, 0);

    for (int i = 0; i < 5; i++) pulse(4'b0001, 4'd0, 4'd0);
    check("five_hits", score, 5);
    pulse(4'b0111, 4'b1000, 4'd0);
    check("netted_score", score, 6);
    check("netted_lives", lives, 1);

    idle_until_due();
    step(4'd0, 4'b0001, 4'd0, 1'b0, 1'b0);
    check("over_flag", game_over, 1);
    check("over_no_spawn", spawn, 0);
    check("over_event_applied", score, 4);
    idle(1);
    pulse(4'b0001, 4'd0, 4'd0);
    check("over_hit_ignored", score, 4);

    step(4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
    check("restart_score", score, 0);
    check("restart_lives", lives, 3);

    for (int i = 0; i < 30; i++) pulse(4'b1111, 4'd0, 4'd0);
    check("max_speed", light_speed, 15);
    check("max_speed_score", score, 120);
    wait_spawn(t_a);
    wait_spawn(t_b);
    check("min_gap_spacing", t_b - t_a, MIN_GAP);

    for (int i = 0; i < 260; i++) pulse(4'b1111, 4'd0, 4'd0);
    check("score_ceiling", score, 1023);

    pulse(4'd0, 4'b0001, 4'd0);
    pulse(4'd0, 4'b0010, 4'd0);
    idle_until_due();
    step(4'd0, 4'b0100, 4'd0, 1'b0, 1'b0);
    check("three_lost_lives", lives, 0);
    check("three_lost_over", game_over, 1);
    check("three_lost_no_spawn", spawn, 0);
    check("three_lost_score", score, 1017);
    idle(1);

    step(4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) begin
      rl = ($urandom_range(0, 19) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'd0;
      step(4'($urandom_range(0, 15)), rl, 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)),
           1'b0, 1'b0);
    end

    step(4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) pulse(4'b0011, 4'd0, 4'd0);
    step(4'b1111, 4'd0, 4'd0, 1'b1, 1'b1);
    check("midgame_reset_score", score, 0);
    check("midgame_reset_lives", lives, 0);
    check("midgame_reset_speed", light_speed, 0);
    check("midgame_reset_playing", playing, 0);
    check("midgame_reset_spawn", spawn, 0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Game-control block that drives the four note columns and scores the player. It generates pseudo-random single-cycle spawn pulses into each column's bottom row and sets the shared light speed. It consumes each column's hit, lost-light and empty-press indications to maintain score, lives, speed level and game state. It sits between the four light columns and the score/lives display logic.

## Interface
- BASE_GAP, 64: spawn spacing in clk cycles at speed level 0
- GAP_STEP, 4: spacing reduction per speed level
- MIN_GAP, 16: floor on spawn spacing; must be ≥ 2
- LEVEL_PTS, 8: hits needed per speed-level increment
- START_LIVES, 3: lives loaded at game start, 1..7

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a game; accepted in IDLE or OVER only
- hit  in  4  per column: OR of that column's user_press vector
- lost  in  4  per column: light_lost
- empty  in  4  per column: empty_press
- spawn  out  4  one-cycle pulse per column, drives root_spawn_signal
- light_speed  out  4  speed level 0..15, shared by all columns
- score  out  10  current score, 0..1023
- lives  out  3  remaining lives
- playing  out  1  high in PLAY
- game_over  out  1  high in OVER

## Operation
- FSM has three states: IDLE, PLAY and OVER.
  - Reset goes to IDLE.
  - start in IDLE or OVER goes to PLAY. start in PLAY is ignored.
  - In PLAY, the cycle lives reaches 0 goes to OVER.
- On start:
  - score ← 0
  - lives ← START_LIVES
  - light_speed ← 0
  - hit accumulator ← 0
  - gap counter ← BASE_GAP−1
- LFSR:
  - 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset.
  - Advances every cycle in all states.
- Spawning happens in PLAY only.
  - The gap counter decrements each cycle.
  - When it reads 0, assert spawn[lfsr[1:0]] for one cycle and reload the counter with gap(light_speed)−1.
  - gap(L) = max(MIN_GAP, BASE_GAP − L·GAP_STEP), computed in 8 bits with no underflow.
  - Exactly one column spawns per pulse.
- Event detection:
  - hit, lost and empty are rising-edge detected per bit against a registered previous value.
  - Previous-value registers are cleared on reset and updated in every state.
  - A held-high input counts once.
- Scoring applies in PLAY only:
  - delta = (#hit edges) − 2·(#lost edges) − (#empty edges), as a 12-bit signed value.
  - score ← clamp(score + delta, 0, 1023).
  - lives ← max(0, lives − #lost edges).
- Speed:
  - The hit accumulator adds #hit edges.
  - When the accumulator is ≥ LEVEL_PTS, subtract LEVEL_PTS and increment light_speed, saturating at 15.
  - At most one level step per cycle.
  - light_speed never decreases within a game.
- IDLE and OVER:
  - spawn is held at 0 and events are ignored.
  - score, lives and light_speed hold their last values.

## Timing
- Reset values:
  - state IDLE, spawn 0, light_speed 0, score 0, lives 0
  - playing 0, game_over 0, lfsr 8'hA5
- start sampled high at edge t: playing=1 after t. The first spawn pulse is high BASE_GAP cycles after playing rises.
- Successive spawns are exactly gap(L) cycles apart (rising to rising), where L is light_speed at reload.
- Event latency is 1: an input first sampled high at edge t updates score/lives/light_speed at edge t.
- When lives reaches 0 at edge t:
  - game_over=1 and playing=0 from t.
  - No spawn after t, even if the counter was due.
  - Events at the same edge still apply.
- Simultaneous hit, lost and empty edges in one cycle, across any columns, are netted in a single update.
- reset mid-game overrides everything, including start in the same cycle.
- start coincident with event edges: the start initialisation wins and the events are dropped.

## Test plan
- Reset, start pulse, no events: playing rises the next cycle. First spawn 64 cycles later on column lfsr[1:0]. Next spawns every 64 cycles. Exactly one spawn bit set per pulse.
- 8 separate hit[0] rising edges: score=8, light_speed=1, next reload gap 60. Hold hit[2] high for 20 cycles: score +1 only.
- score=1, lost[1] edge: score=0 (clamped), lives 3→2. Then empty[3] edge: score stays 0.
- Same cycle: hit[0], hit[1], hit[2] edges plus lost[3] edge from score=5 → score=6, lives−1.
- Three lost edges with the spawn counter due in the last cycle: lives=0, game_over=1, no spawn. A later hit is ignored. A start restarts with score 0, lives 3.
- Drive 15 levels (120 hits): light_speed=15, gap=16 (MIN_GAP floor). Assert reset mid-game: all outputs return to reset values.
